// File: rtl/width_conv_pkg.sv
// Shared definitions for the width reductor / expander pair.
package width_conv_pkg;

    localparam int DEF_W_DATA = 16;
    localparam int DEF_NO     = 4;

    // Width of a lane-count field able to hold 0..no.
    function automatic int calc_w_cnt(input int no);
        return $clog2(no + 1);
    endfunction

    // Wide word as an array of lanes; lane 0 occupies the LSBs.
    typedef logic [DEF_NO-1:0][DEF_W_DATA-1:0] lane_arr_t;

endpackage

// File: rtl/width_expander.sv
// Packs up to NO consecutive narrow elements into one registered wide word.
// A word closes when NO elements are collected or an element carries last.
module width_expander
    import width_conv_pkg::*;
#(
    parameter  int W_DATA = 16,
    parameter  int NO     = 4,
    localparam int W_CNT  = calc_w_cnt(NO)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic [W_DATA:0]             din_data,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [W_CNT+NO*W_DATA:0]    dout_data
);

    localparam int               W_IDX   = $clog2(NO);
    localparam logic [W_IDX-1:0] CNT_TOP = W_IDX'(NO - 1);

    typedef logic [NO-1:0][W_DATA-1:0] lanes_t;

    logic [W_IDX-1:0]  cnt_q, cnt_d;
    logic [W_DATA-1:0] buf_q [NO-1];
    logic [W_DATA-1:0] buf_d [NO-1];
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [W_CNT-1:0]  nlanes_q, nlanes_d;
    lanes_t            lanes_q, lanes_d;

    logic              din_last;
    logic [W_DATA-1:0] din_elem;
    logic              closing;
    logic              accept;

    assign din_last = din_data[W_DATA];
    assign din_elem = din_data[W_DATA-1:0];

    // An element closes the word when it fills the last lane or carries last.
    assign closing = (cnt_q == CNT_TOP) || din_last;

    // Non-closing elements only touch the buffer, so they never wait on the output.
    assign din_ready = !valid_q || dout_ready || !closing;
    assign accept    = din_valid && din_ready;

    assign dout_valid = valid_q;
    assign dout_data  = {last_q, nlanes_q, lanes_q};

    // Next-state: buffer fill on non-closing elements, output load on closing ones.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        valid_d  = valid_q;
        last_d   = last_q;
        nlanes_d = nlanes_q;
        lanes_d  = lanes_q;

        // Downstream handshake drains the register; a simultaneous close reloads it below.
        if (dout_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (closing) begin
                lanes_d = '0;
                for (int k = 0; k < NO - 1; k++) begin
                    if (W_IDX'(k) < cnt_q) begin
                        lanes_d[k] = buf_q[k];
                    end
                end
                for (int k = 0; k < NO; k++) begin
                    if (W_IDX'(k) == cnt_q) begin
                        lanes_d[k] = din_elem;
                    end
                end
                nlanes_d = W_CNT'(cnt_q) + W_CNT'(1);
                last_d   = din_last;
                valid_d  = 1'b1;
                cnt_d    = '0;
            end else begin
                for (int k = 0; k < NO - 1; k++) begin
                    if (W_IDX'(k) == cnt_q) begin
                        buf_d[k] = din_elem;
                    end
                end
                cnt_d = cnt_q + W_IDX'(1);
            end
        end
    end

    // State registers: fill counter, lane buffer and output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            nlanes_q <= '0;
            lanes_q  <= '0;
            // NOTE: the buffer is tiny and cleared on reset so a dropped partial word leaves no trace.
            for (int k = 0; k < NO - 1; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            nlanes_q <= nlanes_d;
            lanes_q  <= lanes_d;
            for (int k = 0; k < NO - 1; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

endmodule

// File: tb/tb_width_expander.sv
// Self-checking bench for width_expander: directed scenarios plus a random soak
// against a queue-based lane-packing model.
`timescale 1ns/1ps
module tb_width_expander;

    localparam int W_DATA = 16;
    localparam int NO     = 4;
    localparam int W_CNT  = 3;
    localparam int W_OUT  = 1 + W_CNT + NO * W_DATA;

    logic              clk = 1'b0;
    logic              rst;
    logic              din_valid;
    logic              din_ready;
    logic [W_DATA:0]   din_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [W_OUT-1:0]  dout_data;

    int errors = 0;
    int checks = 0;

    // Soak model: elements of the word being collected, and words owed downstream.
    logic [W_DATA-1:0] part_q [$];
    logic [W_OUT-1:0]  exp_q  [$];

    width_expander #(.W_DATA(W_DATA), .NO(NO)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W_OUT-1:0] word(input logic l, input int n,
                                              input logic [NO*W_DATA-1:0] lanes);
        return {l, W_CNT'(n), lanes};
    endfunction

    // Offer one element and hold it until accepted; returns at edge+1 of the handshake.
    task automatic send(input logic [W_DATA-1:0] elem, input logic last, input string tag);
        int waited = 0;
        din_valid = 1'b1;
        din_data  = {last, elem};
        #1;
        while (!din_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake timeout: din_ready=%b required 1", tag, din_ready);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        din_valid  = 1'b0;
        din_data   = {1'b1, 16'h0};
        dout_ready = 1'b0;
        rst        = 1'b1;
        #12;
        checks++;
        if (dout_valid !== 1'b0 || dout_data !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h required 0/0", dout_valid, dout_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: din_ready=%b required 1", din_ready);
        end
    endtask

    task automatic test_round_trip();
        logic [W_OUT-1:0] exp_w;
        exp_w = word(1'b1, 4, 64'h4444_3333_2222_1111);
        dout_ready = 1'b1;
        send(16'h1111, 1'b0, "rt_e0");
        send(16'h2222, 1'b0, "rt_e1");
        send(16'h3333, 1'b0, "rt_e2");
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL rt_partial_valid: valid=%b required 0", dout_valid);
        end
        send(16'h4444, 1'b1, "rt_e3");
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== exp_w) begin
            errors++;
            $display("FAIL rt_word: valid=%b data=%h required 1/%h", dout_valid, dout_data, exp_w);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL rt_drain: valid=%b required 0", dout_valid);
        end
    endtask

    task automatic test_early_last();
        logic [W_OUT-1:0] exp_w;
        dout_ready = 1'b1;
        send(16'hAAAA, 1'b0, "el_e0");
        send(16'hBBBB, 1'b1, "el_e1");
        exp_w = word(1'b1, 2, 64'h0000_0000_BBBB_AAAA);
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== exp_w) begin
            errors++;
            $display("FAIL early_last_word: valid=%b data=%h required 1/%h", dout_valid, dout_data, exp_w);
        end
        @(posedge clk); #1;
        send(16'hCCCC, 1'b1, "el_e2");
        exp_w = word(1'b1, 1, 64'h0000_0000_0000_CCCC);
        checks++;
        if (dout_data !== exp_w) begin
            errors++;
            $display("FAIL early_last_lane0: data=%h required %h", dout_data, exp_w);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [W_DATA-1:0] e [8];
        logic [W_OUT-1:0]  w1, w2;
        int                idx      = 0;
        int                unstable = 0;
        logic              accepted;
        for (int i = 0; i < 8; i++) e[i] = W_DATA'(16'h5000 + i);
        w1 = word(1'b0, 4, {e[3], e[2], e[1], e[0]});
        w2 = word(1'b0, 4, {e[7], e[6], e[5], e[4]});
        dout_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            din_valid = 1'b1;
            din_data  = {1'b0, e[idx]};
            #1;
            accepted = din_ready;
            @(posedge clk); #1;
            if (accepted) idx++;
            if (idx >= 4 && dout_data !== w1) unstable++;
        end
        din_data = {1'b0, e[idx]};
        #1;
        checks++;
        if (idx !== 7) begin
            errors++;
            $display("FAIL bp_accepted: accepted=%0d required 7", idx);
        end
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: din_ready=%b required 0", din_ready);
        end
        checks++;
        if (unstable !== 0 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: unstable_cycles=%0d valid=%b required 0/1", unstable, dout_valid);
        end
        dout_ready = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: din_ready=%b required 1", din_ready);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== w2) begin
            errors++;
            $display("FAIL bp_word2: valid=%b data=%h required 1/%h", dout_valid, dout_data, w2);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b required 0", dout_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W_OUT-1:0] exp_w;
        dout_ready = 1'b1;
        send(16'h0DD1, 1'b1, "b2b_e0");
        din_valid = 1'b1;
        din_data  = {1'b1, 16'h0DD2};
        #1;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b valid=%b required 1/1", din_ready, dout_valid);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        exp_w = word(1'b1, 1, 64'h0000_0000_0000_0DD2);
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== exp_w) begin
            errors++;
            $display("FAIL b2b_word: valid=%b data=%h required 1/%h", dout_valid, dout_data, exp_w);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_word();
        logic [W_OUT-1:0] exp_w;
        dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(W_DATA'(16'h6000 + i), 1'b0, "rmw_fill");
        din_data = {1'b1, 16'h0};
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || dout_data !== '0) begin
            errors++;
            $display("FAIL rmw_async: valid=%b data=%h required 0/0", dout_valid, dout_data);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmw_release_ready: din_ready=%b required 1", din_ready);
        end
        dout_ready = 1'b1;
        send(16'h7001, 1'b0, "rmw_e0");
        send(16'h7002, 1'b0, "rmw_e1");
        send(16'h7003, 1'b0, "rmw_e2");
        send(16'h7004, 1'b1, "rmw_e3");
        exp_w = word(1'b1, 4, 64'h7004_7003_7002_7001);
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== exp_w) begin
            errors++;
            $display("FAIL rmw_clean_word: valid=%b data=%h required 1/%h", dout_valid, dout_data, exp_w);
        end
        @(posedge clk); #1;
    endtask

    // One soak cycle: compare against the model before the edge, then advance the model.
    task automatic soak_cycle(input logic v, input logic [W_DATA:0] d, input logic r);
        logic                 exp_valid, exp_ready, closing, fire_in, fire_out;
        logic [NO*W_DATA-1:0] lanes;
        din_valid  = v;
        din_data   = d;
        dout_ready = r;
        #1;
        exp_valid = (exp_q.size() != 0);
        closing   = d[W_DATA] || (part_q.size() == NO - 1);
        exp_ready = !exp_valid || r || !closing;
        checks++;
        if (dout_valid !== exp_valid || din_ready !== exp_ready) begin
            errors++;
            $display("FAIL soak_hs: valid=%b ready=%b required %b/%b", dout_valid, din_ready, exp_valid, exp_ready);
        end
        if (exp_valid) begin
            checks++;
            if (dout_data !== exp_q[0]) begin
                errors++;
                $display("FAIL soak_data: data=%h required %h", dout_data, exp_q[0]);
            end
        end
        fire_in  = v && exp_ready;
        fire_out = exp_valid && r;
        @(posedge clk); #1;
        if (fire_out) void'(exp_q.pop_front());
        if (fire_in) begin
            part_q.push_back(d[W_DATA-1:0]);
            if (closing) begin
                lanes = '0;
                foreach (part_q[i]) lanes[i*W_DATA +: W_DATA] = part_q[i];
                exp_q.push_back(word(d[W_DATA], part_q.size(), lanes));
                part_q.delete();
            end
        end
    endtask

    task automatic test_random_soak();
        logic v, r, l;
        part_q.delete();
        exp_q.delete();
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            l = ($urandom_range(0, 3) == 0);
            soak_cycle(v, {l, W_DATA'($urandom)}, r);
        end
        for (int c = 0; c < 4; c++) soak_cycle(1'b0, '0, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL soak_drain: pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_early_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/width_expander.md
# width_expander

Downstream counterpart of the width reductor stage: consumes a narrow DTI stream of `{last, element}` words and packs up to NO consecutive elements into one wide output word. A word is closed either when NO elements have been collected or when an element arrives with `last` set. The output is registered, so the wide path is re-timed, and the reductor→expander round trip is an identity on full words.

## Interface
Parameters:
- W_DATA, 16, width of one element.
- NO, 4, elements per wide word; legal range NO ≥ 2.
- W_CNT (derived, not overridable), $clog2(NO+1), width of the lane-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- din  dti.consumer  1+W_DATA  data = {last, element}; last is the MSB.
- dout  dti.producer  1+W_CNT+NO*W_DATA  data = {last, nlanes, lanes}.
  - lanes[k] is the element at position k of the word; lane 0 is the LSBs.
  - nlanes counts the valid lanes, 1..NO.

## Operation
- State:
  - lane buffer: NO-1 entries of W_DATA.
  - fill counter cnt: $clog2(NO) bits, range 0..NO-1.
  - output register: data plus valid.
- Accepting an element (din.valid && din.ready):
  - If cnt < NO-1 and din last = 0, the element is "non-closing":
    - write it to buffer[cnt];
    - cnt <= cnt+1.
  - If cnt == NO-1 or din last = 1, the element is "closing":
    - load the output register with lanes 0..cnt-1 from the buffer;
    - place the element in lane cnt;
    - zero-fill lanes cnt+1..NO-1;
    - set nlanes = cnt+1 and last = din last;
    - set dout.valid = 1 and cnt <= 0.
- din.ready = !dout.valid || dout.ready || (cnt != NO-1 && din last == 0).
  - Non-closing elements are always accepted, even while the output is stalled.
  - ready depends combinationally on dout.ready and on the din last bit, never on din.valid.
- Output drain: dout.valid stays 1 and dout.data stays stable until dout.ready.
  - A handshake with no simultaneous closing element clears dout.valid.
  - A handshake in the same cycle as a closing element reloads the register; dout.valid stays 1.
- Arithmetic: nlanes is zero-extended cnt+1 in W_CNT bits and never wraps. cnt wraps only through the explicit reset-to-0 on close.
- Reset (async, any time, including mid-word):
  - cnt = 0, dout.valid = 0, dout.data = 0, buffer cleared to 0;
  - partially collected elements are discarded.
- No state machine beyond cnt plus the output valid bit. The two effective states are ACCUM (dout.valid = 0) and HOLD (dout.valid = 1); accumulation continues in both.

## Timing
- Latency: 1 cycle from the closing element's handshake to dout.valid.
- Throughput:
  - 1 element per cycle sustained;
  - 1 wide word per NO cycles with full words;
  - 1 per cycle when every element carries last.
- Stall: a closing element waits (din.ready = 0) only while dout.valid && !dout.ready.
- Reset release: din.ready = 1 in the first cycle after rst deasserts.

## Structure
- Shared package `width_conv_pkg`:
  - W_CNT computation function;
  - the lane-array typedef `logic [NO-1:0][W_DATA-1:0]`, shared with the reductor.
- Single module; no sub-module. The output register is inline; the buffer plus cnt is small enough to stay in the same always_ff.

## Test plan
- Round trip, NO=4, W_DATA=16:
  - stimulus: elements 0x1111, 0x2222, 0x3333, 0x4444 (last on the 4th), dout.ready = 1;
  - required: one word, lanes = 0x4444_3333_2222_1111, nlanes = 4, last = 1, one cycle after the 4th handshake.
- Early last:
  - stimulus: 0xAAAA, then 0xBBBB with last = 1;
  - required: lanes = 0x0000_0000_BBBB_AAAA, nlanes = 2, last = 1; the next element lands in lane 0.
- Backpressure:
  - stimulus: dout.ready = 0 for 10 cycles while 8 elements are offered;
  - required: the first word is held stable; elements 5–7 are accepted; element 8 is stalled.
  - After dout.ready = 1, the second word is delivered with lanes 4..7 intact and no loss or duplication.
- Simultaneous drain and close: dout.ready = 1 in the same cycle as a closing handshake → dout.valid stays 1 and the new word appears on the next cycle.
- Reset mid-word:
  - stimulus: assert rst asynchronously after 2 elements;
  - required: dout.valid = 0 immediately, dout.data = 0, and the next 4 elements form a clean word with nlanes = 4.
- Randomized soak: random valid/ready patterns with random last placement, checked against a scoreboard model of lane packing.
